// File: rtl/piso_ctrl_pkg.sv
// Shared types and helpers for the parallel-in/serial-out sequencer.
package piso_ctrl_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_t;

  // A one-bit word still needs a one-bit counter.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-load shift register; vacated positions fill with zero, load wins over shift.
module piso_shift_reg
  import piso_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             serial
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;
  logic [WIDTH-1:0] shifted;

  assign shifted = LSB_FIRST ? (sr_q >> 1) : (sr_q << 1);

  always_comb begin
    sr_d = sr_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (load) begin
        sr_d[i] = d[i];
      end else if (shift) begin
        sr_d[i] = shifted[i];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign serial = LSB_FIRST ? sr_q[0] : sr_q[WIDTH-1];

endmodule

// File: rtl/piso_serializer_ctrl.sv
// Word-to-bit sequencer: valid/ready word intake, per-tick bit advance, gapless word chaining.
module piso_serializer_ctrl
  import piso_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] DATA_IN,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic             SER_EN,
  output logic             Serial_OUT,
  output logic             OUT_VALID,
  output logic             FRAME_START,
  output logic             LAST_BIT
);

  localparam int unsigned     CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]   LAST_CNT = CW'(WIDTH - 1);

  piso_state_t   state_q;
  piso_state_t   state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  logic in_shift;
  logic last_bit;
  logic accept;
  logic sr_shift;
  logic sr_serial;

  assign in_shift = (state_q == SHIFT);
  assign last_bit = in_shift && (cnt_q == LAST_CNT);

  // Ready on the final bit's tick lets the next word load on the same edge the last bit retires.
  assign IN_READY = !RST && (!in_shift || (last_bit && SER_EN));
  assign accept   = IN_VALID && IN_READY;
  assign sr_shift = in_shift && SER_EN && !last_bit;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (accept) begin
      state_d = SHIFT;
      cnt_d   = '0;
    end else if (in_shift && SER_EN) begin
      if (last_bit) begin
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  piso_shift_reg #(
    .WIDTH     (WIDTH),
    .LSB_FIRST (LSB_FIRST)
  ) u_sr (
    .CLK    (CLK),
    .RST    (RST),
    .load   (accept),
    .shift  (sr_shift),
    .d      (DATA_IN),
    .serial (sr_serial)
  );

  assign Serial_OUT  = in_shift && sr_serial;
  assign OUT_VALID   = in_shift;
  assign FRAME_START = in_shift && (cnt_q == '0);
  assign LAST_BIT    = last_bit;

endmodule

// File: tb/tb_piso_serializer_ctrl.sv
// Scoreboard bench for piso_serializer_ctrl (4-bit LSB-first and 8-bit MSB-first instances).
module tb_piso_serializer_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0] a_data   = '0;
  logic       a_valid  = 1'b0;
  logic       a_ser_en = 1'b0;
  logic       a_ready, a_ser, a_ov, a_fs, a_lb;

  logic [7:0] b_data   = '0;
  logic       b_valid  = 1'b0;
  logic       b_ser_en = 1'b0;
  logic       b_ready, b_ser, b_ov, b_fs, b_lb;

  piso_serializer_ctrl #(.WIDTH(4), .LSB_FIRST(1'b1)) dut_a (
    .CLK(clk), .RST(rst), .DATA_IN(a_data), .IN_VALID(a_valid), .IN_READY(a_ready),
    .SER_EN(a_ser_en), .Serial_OUT(a_ser), .OUT_VALID(a_ov), .FRAME_START(a_fs), .LAST_BIT(a_lb)
  );

  piso_serializer_ctrl #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_b (
    .CLK(clk), .RST(rst), .DATA_IN(b_data), .IN_VALID(b_valid), .IN_READY(b_ready),
    .SER_EN(b_ser_en), .Serial_OUT(b_ser), .OUT_VALID(b_ov), .FRAME_START(b_fs), .LAST_BIT(b_lb)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic b;
    logic fs;
    logic lb;
  } exp_t;

  exp_t exp_q[$];
  logic log_q[$];
  int   ov_cnt = 0;

  // Scoreboard for dut_a: words pushed as bit sequences on accept, popped when a bit is consumed.
  always @(negedge clk) begin
    exp_t e;
    logic rdy_exp;
    #1;
    if (rst) begin
      exp_q.delete();
      checks++;
      if (a_ready !== 1'b0) begin
        errors++;
        $display("FAIL ready_in_reset: got %b want 0", a_ready);
      end
    end else begin
      checks++;
      if (a_ov !== (exp_q.size() != 0)) begin
        errors++;
        $display("FAIL out_valid: got %b want %b", a_ov, exp_q.size() != 0);
      end
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        rdy_exp = e.lb & a_ser_en;
        checks++;
        if ({a_ser, a_fs, a_lb} !== {e.b, e.fs, e.lb}) begin
          errors++;
          $display("FAIL bit_stream: got ser/fs/lb=%b%b%b want %b%b%b",
                   a_ser, a_fs, a_lb, e.b, e.fs, e.lb);
        end
      end else begin
        rdy_exp = 1'b1;
        checks++;
        if ({a_ser, a_fs, a_lb} !== 3'b000) begin
          errors++;
          $display("FAIL idle_outputs: got ser/fs/lb=%b%b%b want 000", a_ser, a_fs, a_lb);
        end
      end
      checks++;
      if (a_ready !== rdy_exp) begin
        errors++;
        $display("FAIL in_ready: got %b want %b", a_ready, rdy_exp);
      end
      if (a_ov === 1'b1) ov_cnt++;
      if (a_ov === 1'b1 && a_ser_en && exp_q.size() != 0) begin
        log_q.push_back(a_ser);
        void'(exp_q.pop_front());
      end
      if (a_valid && a_ready === 1'b1) begin
        for (int i = 0; i < 4; i++) begin
          e.b  = a_data[i];
          e.fs = (i == 0);
          e.lb = (i == 3);
          exp_q.push_back(e);
        end
      end
    end
  end

  task automatic src_send(input logic [3:0] w);
    int n = 0;
    @(negedge clk);
    a_data  = w;
    a_valid = 1'b1;
    #2;
    while (a_ready !== 1'b1 && n < 60) begin
      @(negedge clk);
      #2;
      n++;
    end
    checks++;
    if (a_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout: got ready=%b want 1 within 60 cycles", a_ready);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1; a_valid = 1'b1; a_data = 4'hF; a_ser_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #2;
      checks++;
      if (a_ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_ready: got %b want 0", a_ready);
      end
      @(negedge clk);
    end
    #2;
    checks++;
    if ({a_ser, a_ov, a_fs, a_lb, b_ser, b_ov, b_fs, b_lb} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got a=%b%b%b%b b=%b%b%b%b want all 0",
               a_ser, a_ov, a_fs, a_lb, b_ser, b_ov, b_fs, b_lb);
    end
    @(negedge clk);
    rst = 1'b0; a_valid = 1'b0;
    #2;
    checks++;
    if (a_ready !== 1'b1 || a_ov !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: got ready=%b ov=%b want 1 0", a_ready, a_ov);
    end
  endtask

  task automatic test_single;
    logic exp_bits [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    log_q.delete(); ov_cnt = 0; a_ser_en = 1'b1;
    src_send(4'b1011);
    @(negedge clk);
    a_valid = 1'b0;
    repeat (6) @(negedge clk);
    #2;
    checks++;
    if (ov_cnt != 4 || log_q.size() != 4) begin
      errors++;
      $display("FAIL single_count: got ov=%0d bits=%0d want 4 4", ov_cnt, log_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (log_q[i] !== exp_bits[i]) begin
          errors++;
          $display("FAIL single_bit%0d: got %b want %b", i, log_q[i], exp_bits[i]);
        end
      end
    end
    checks++;
    if (a_ov !== 1'b0 || a_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_idle: got ov=%b ready=%b want 0 1", a_ov, a_ready);
    end
  endtask

  task automatic test_back_to_back;
    logic exp_bits [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    log_q.delete(); ov_cnt = 0; a_ser_en = 1'b1;
    src_send(4'hA);
    src_send(4'h5);
    @(negedge clk);
    a_valid = 1'b0;
    repeat (10) @(negedge clk);
    #2;
    checks++;
    if (ov_cnt != 8 || log_q.size() != 8) begin
      errors++;
      $display("FAIL b2b_count: got ov=%0d bits=%0d want 8 8", ov_cnt, log_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (log_q[i] !== exp_bits[i]) begin
          errors++;
          $display("FAIL b2b_bit%0d: got %b want %b", i, log_q[i], exp_bits[i]);
        end
      end
    end
  endtask

  task automatic test_slow_tick;
    logic exp_bits [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    log_q.delete(); ov_cnt = 0; a_ser_en = 1'b0;
    src_send(4'b0110);
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (k == 0) a_valid = 1'b0;
      a_ser_en = (k % 3 == 2);
    end
    @(negedge clk);
    a_ser_en = 1'b1;
    #2;
    checks++;
    if (ov_cnt != 12 || log_q.size() != 4) begin
      errors++;
      $display("FAIL slow_count: got ov=%0d bits=%0d want 12 4", ov_cnt, log_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (log_q[i] !== exp_bits[i]) begin
          errors++;
          $display("FAIL slow_bit%0d: got %b want %b", i, log_q[i], exp_bits[i]);
        end
      end
    end
  endtask

  task automatic test_mid_reset;
    logic exp_bits [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    a_ser_en = 1'b1;
    src_send(4'hF);
    @(negedge clk);
    a_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #2;
    checks++;
    if ({a_ser, a_ov, a_fs, a_lb, a_ready} !== 5'b00001) begin
      errors++;
      $display("FAIL mid_reset_idle: got ser/ov/fs/lb/ready=%b%b%b%b%b want 00001",
               a_ser, a_ov, a_fs, a_lb, a_ready);
    end
    log_q.delete(); ov_cnt = 0;
    src_send(4'h9);
    @(negedge clk);
    a_valid = 1'b0;
    repeat (6) @(negedge clk);
    #2;
    checks++;
    if (ov_cnt != 4 || log_q.size() != 4) begin
      errors++;
      $display("FAIL mid_reset_count: got ov=%0d bits=%0d want 4 4", ov_cnt, log_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (log_q[i] !== exp_bits[i]) begin
          errors++;
          $display("FAIL mid_reset_bit%0d: got %b want %b", i, log_q[i], exp_bits[i]);
        end
      end
    end
  endtask

  task automatic test_msb_first_w8;
    logic exp_bits [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic got [$];
    int n = 0;
    b_ser_en = 1'b1;
    @(negedge clk);
    b_data = 8'hC3; b_valid = 1'b1;
    #2;
    while (b_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      #2;
      n++;
    end
    checks++;
    if (b_ready !== 1'b1) begin
      errors++;
      $display("FAIL w8_accept_timeout: got ready=%b want 1", b_ready);
    end
    @(negedge clk);
    b_valid = 1'b0;
    for (int k = 0; k < 12; k++) begin
      #2;
      if (b_ov === 1'b1) begin
        checks++;
        if (b_fs !== (got.size() == 0) || b_lb !== (got.size() == 7)) begin
          errors++;
          $display("FAIL w8_flags%0d: got fs/lb=%b%b want %b%b", got.size(), b_fs, b_lb,
                   got.size() == 0, got.size() == 7);
        end
        got.push_back(b_ser);
      end
      @(negedge clk);
    end
    checks++;
    if (got.size() != 8) begin
      errors++;
      $display("FAIL w8_count: got %0d want 8", got.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (got[i] !== exp_bits[i]) begin
          errors++;
          $display("FAIL w8_bit%0d: got %b want %b", i, got[i], exp_bits[i]);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_slow_tick();
    test_mid_reset();
    test_msb_first_w8();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
